// File: rtl/hyperram_responder.sv
// hyperram_responder: HyperBus (HyperRAM) target model backed by a 16-bit word array and CR0.
// Ports: i_clk/i_rst system clock and sync reset; dram_ck sampled as data (period >= 4 i_clk);
//        dram_rst_l/dram_cs_l active-low device reset and select; dram_dq_in/out/oe_l byte lane;
//        dram_rwds_in (write mask) / dram_rwds_out / dram_rwds_oe_l strobe. All outputs registered.
module hyperram_responder #(
   parameter int          ADDR_W   = 10,
   parameter int          LATENCY  = 6,
   parameter bit          FIXED_2X = 1'b1,
   parameter logic [15:0] ID0      = 16'h0C81,
   parameter logic [15:0] CR0_RST  = 16'h8F1F
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       dram_ck,
   input  logic       dram_rst_l,
   input  logic       dram_cs_l,
   input  logic [7:0] dram_dq_in,
   output logic [7:0] dram_dq_out,
   output logic       dram_dq_oe_l,
   input  logic       dram_rwds_in,
   output logic       dram_rwds_out,
   output logic       dram_rwds_oe_l
);
   localparam int LC = FIXED_2X ? 2 * LATENCY : LATENCY;
   typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WR, S_RD, S_REGWR} state_t;
   state_t            r_state, w_state_n;
   logic              r_ck_q;
   logic [39:0]       r_ca, w_ca_n;
   logic [7:0]        r_cnt, w_cnt_n;
   logic [ADDR_W-1:0] r_addr, w_addr_n;
   logic              r_rd, w_rd_n, r_reg, w_reg_n, r_reg0, w_reg0_n;
   logic [7:0]        r_hi, w_hi_n, r_lo, w_lo_n;
   logic              r_hmask, w_hmask_n, r_half, w_half_n;
   logic [15:0]       r_cr0, w_cr0_n, r_pre;
   logic [7:0]        r_dq_out, w_dq_n;
   logic              r_dq_oe_l, w_dq_oe_l_n, r_rwds_out, w_rwds_n, r_rwds_oe_l, w_rwds_oe_l_n;
   logic              w_we_hi, w_we_lo;
   logic [15:0]       r_mem [2**ADDR_W];
   logic              w_reset, w_rise, w_fall, w_data_rise, w_data_fall;
   logic [47:0]       w_ca;
   logic [31:0]       w_caddr;
   logic [15:0]       w_word;
   assign w_reset = i_rst | ~dram_rst_l;
   assign w_rise  = dram_ck & ~r_ck_q;
   assign w_fall  = ~dram_ck & r_ck_q;
   assign w_ca    = {r_ca, dram_dq_in};
   assign w_caddr = {w_ca[44:16], w_ca[2:0]};
   // register space decodes ID0 on the full, untruncated address so CR0 at 0x800 is not aliased
   assign w_word  = r_reg ? (r_reg0 ? ID0 : r_cr0) : r_pre;
   // the LAT rise that ends the latency is itself the first data rise
   assign w_data_rise = w_rise & ((r_state == S_LAT & r_cnt == 8'(LC)) | r_state == S_WR
                                  | r_state == S_RD | r_state == S_REGWR);
   assign w_data_fall = w_fall & (r_state == S_WR | r_state == S_RD | r_state == S_REGWR);
   assign dram_dq_out    = r_dq_out;
   assign dram_dq_oe_l   = r_dq_oe_l;
   assign dram_rwds_out  = r_rwds_out;
   assign dram_rwds_oe_l = r_rwds_oe_l;
   always_comb begin
      w_state_n     = r_state;
      w_ca_n        = r_ca;
      w_cnt_n       = r_cnt;
      w_addr_n      = r_addr;
      w_rd_n        = r_rd;
      w_reg_n       = r_reg;
      w_reg0_n      = r_reg0;
      w_hi_n        = r_hi;
      w_lo_n        = r_lo;
      w_hmask_n     = r_hmask;
      w_half_n      = r_half;
      w_cr0_n       = r_cr0;
      w_dq_n        = r_dq_out;
      w_dq_oe_l_n   = r_dq_oe_l;
      w_rwds_n      = r_rwds_out;
      w_rwds_oe_l_n = r_rwds_oe_l;
      w_we_hi       = 1'b0;
      w_we_lo       = 1'b0;
      if (dram_cs_l) begin
         w_state_n     = S_IDLE;
         w_half_n      = 1'b0;
         w_dq_n        = 8'h00;
         w_dq_oe_l_n   = 1'b1;
         w_rwds_n      = 1'b0;
         w_rwds_oe_l_n = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_n     = S_CA;
               w_cnt_n       = 8'd0;
               w_half_n      = 1'b0;
               w_rwds_oe_l_n = 1'b0;
               w_rwds_n      = FIXED_2X;
            end
            S_CA: if (w_rise | w_fall) begin
               w_ca_n  = w_ca[39:0];
               w_cnt_n = r_cnt + 8'd1;
               if (r_cnt == 8'd5) begin
                  w_cnt_n       = 8'd0;
                  w_rd_n        = w_ca[47];
                  w_reg_n       = w_ca[46];
                  w_reg0_n      = w_caddr == 32'd0;
                  w_addr_n      = w_caddr[ADDR_W-1:0];
                  w_state_n     = (!w_ca[47] && w_ca[46]) ? S_REGWR : S_LAT;
                  w_rwds_n      = 1'b0;
                  w_rwds_oe_l_n = ~w_ca[47];
               end
            end
            S_LAT: if (w_rise) begin
               w_cnt_n = r_cnt + 8'd1;
               if (r_cnt == 8'(LC)) w_state_n = r_rd ? S_RD : S_WR;
            end
            default: ;
         endcase
         if (w_data_rise) begin
            if (r_rd) begin
               w_lo_n        = w_word[7:0];
               w_dq_n        = w_word[15:8];
               w_dq_oe_l_n   = 1'b0;
               w_rwds_n      = 1'b1;
               w_rwds_oe_l_n = 1'b0;
            end else begin
               w_hi_n    = dram_dq_in;
               w_hmask_n = dram_rwds_in;
               w_half_n  = 1'b1;
            end
         end
         if (w_data_fall) begin
            if (r_rd) begin
               w_dq_n   = r_lo;
               w_rwds_n = 1'b0;
               w_addr_n = r_addr + ADDR_W'(1);
               w_reg0_n = 1'b0;
            end else if (r_half) begin
               w_half_n = 1'b0;
               if (r_reg) begin
                  w_cr0_n = (r_cnt == 8'd0) ? {r_hi, dram_dq_in} : r_cr0;
                  w_cnt_n = 8'd1;
               end else begin
                  w_we_hi  = ~r_hmask;
                  w_we_lo  = ~dram_rwds_in;
                  w_addr_n = r_addr + ADDR_W'(1);
               end
            end
         end
      end
   end
   always_ff @(posedge i_clk) begin
      r_ck_q <= dram_ck;
      if (w_reset) begin
         r_state     <= S_IDLE;
         r_ca        <= '0;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_rd        <= 1'b0;
         r_reg       <= 1'b0;
         r_reg0      <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_hmask     <= 1'b0;
         r_half      <= 1'b0;
         r_cr0       <= CR0_RST;
         r_dq_out    <= '0;
         r_dq_oe_l   <= 1'b1;
         r_rwds_out  <= 1'b0;
         r_rwds_oe_l <= 1'b1;
      end else begin
         r_state     <= w_state_n;
         r_ca        <= w_ca_n;
         r_cnt       <= w_cnt_n;
         r_addr      <= w_addr_n;
         r_rd        <= w_rd_n;
         r_reg       <= w_reg_n;
         r_reg0      <= w_reg0_n;
         r_hi        <= w_hi_n;
         r_lo        <= w_lo_n;
         r_hmask     <= w_hmask_n;
         r_half      <= w_half_n;
         r_cr0       <= w_cr0_n;
         r_dq_out    <= w_dq_n;
         r_dq_oe_l   <= w_dq_oe_l_n;
         r_rwds_out  <= w_rwds_n;
         r_rwds_oe_l <= w_rwds_oe_l_n;
      end
   end
   // array is never cleared; the prefetch register tracks r_addr so a word is ready by the next rise
   always_ff @(posedge i_clk) begin
      if (!w_reset && w_we_hi) r_mem[r_addr][15:8] <= r_hi;
      if (!w_reset && w_we_lo) r_mem[r_addr][7:0] <= dram_dq_in;
      r_pre <= r_mem[r_addr];
   end
endmodule

// File: tb/tb_hyperram_responder.sv
// tb_hyperram_responder: bus-level bench for hyperram_responder with vector table and random model.
module tb_hyperram_responder;
   logic       clk = 1'b0, i_rst = 1'b1, dram_ck = 1'b0, dram_rst_l = 1'b1, dram_cs_l = 1'b1;
   logic [7:0] dram_dq_in = 8'h00, dram_dq_out;
   logic       dram_dq_oe_l, dram_rwds_in = 1'b0, dram_rwds_out, dram_rwds_oe_l;
   int         n_cmp = 0, n_bad = 0;
   hyperram_responder dut (
      .i_clk(clk), .i_rst(i_rst), .dram_ck(dram_ck), .dram_rst_l(dram_rst_l),
      .dram_cs_l(dram_cs_l), .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out),
      .dram_dq_oe_l(dram_dq_oe_l), .dram_rwds_in(dram_rwds_in), .dram_rwds_out(dram_rwds_out),
      .dram_rwds_oe_l(dram_rwds_oe_l)
   );
   always #5 clk = ~clk;
   typedef struct {
      bit          rd;
      bit          rg;
      logic [31:0] a;
      int          n;
      logic [63:0] d;
      logic [3:0]  hm;
      logic [63:0] e;
   } vec_t;
   vec_t tv [14];
   function automatic vec_t mk(bit rd, bit rg, logic [31:0] a, int n, logic [63:0] d,
                               logic [3:0] hm, logic [63:0] e);
      vec_t v;
      v.rd = rd; v.rg = rg; v.a = a; v.n = n; v.d = d; v.hm = hm; v.e = e;
      return v;
   endfunction
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask
   task automatic half(input logic [7:0] b, input logic m);
      @(negedge clk);
      dram_dq_in = b;
      dram_rwds_in = m;
      dram_ck = ~dram_ck;
      @(negedge clk);
   endtask
   task automatic xfer(input bit rd, input bit rg, input logic [31:0] a, input int n,
                       input logic [63:0] wd, input logic [3:0] hm, input logic [3:0] lm,
                       input bit ab, input bit st, output logic [63:0] rdat);
      logic [47:0] ca;
      logic [7:0]  hi, lo;
      int          lat, viol;
      rdat = '0;
      ca = {rd, rg, 1'b0, a[31:3], 13'h0, a[2:0]};
      @(negedge clk);
      dram_cs_l = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ca_rwds", 32'({dram_rwds_oe_l, dram_rwds_out}), 32'b01);
      for (int i = 0; i < 6; i++) begin
         half(ca[47-8*i -: 8], 1'b0);
         if (st && i == 2) begin
            repeat (20) @(negedge clk);
            chk("stall_ca_rwds", 32'({dram_rwds_oe_l, dram_rwds_out}), 32'b01);
         end
      end
      chk("ca_end_rwds_oe", 32'(dram_rwds_oe_l), 32'(!rd));
      lat = (rg && !rd) ? 0 : 12;
      viol = 0;
      for (int r = 0; r < 2 * lat; r++) begin
         half(8'h00, 1'b0);
         if ({dram_dq_oe_l, dram_rwds_oe_l} !== (rd ? 2'b10 : 2'b11) || (rd && dram_rwds_out !== 1'b0))
            viol++;
      end
      chk("lat_hold", 32'(viol), 32'd0);
      for (int w = 0; w < n; w++) begin
         if (rd) begin
            half(8'h00, 1'b0);
            hi = dram_dq_out;
            chk("rd_rise_strobe", 32'({dram_dq_oe_l, dram_rwds_oe_l, dram_rwds_out}), 32'b001);
         end else half(wd[16*w+8 +: 8], hm[w]);
         if (ab) begin
            @(negedge clk);
            dram_cs_l = 1'b1;
            dram_ck = 1'b0;
            dram_dq_in = 8'hAD;
            @(negedge clk);
            chk("abort_oe", 32'({dram_dq_oe_l, dram_rwds_oe_l}), 32'b11);
            repeat (2) @(negedge clk);
            return;
         end
         if (rd) begin
            half(8'h00, 1'b0);
            lo = dram_dq_out;
            chk("rd_fall_strobe", 32'({dram_dq_oe_l, dram_rwds_oe_l, dram_rwds_out}), 32'b000);
            rdat[16*w +: 16] = {hi, lo};
         end else half(wd[16*w +: 8], lm[w]);
      end
      @(negedge clk);
      dram_cs_l = 1'b1;
      dram_rwds_in = 1'b0;
      @(negedge clk);
      chk("end_oe", 32'({dram_dq_oe_l, dram_rwds_oe_l}), 32'b11);
      @(negedge clk);
   endtask
   logic [15:0] mm [1024];
   bit          kh [1024], kl [1024];
   int          qa[$], qn[$];
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [63:0] got, wd;
      logic [15:0] cr0m, km;
      logic [31:0] a;
      logic [3:0]  hm, lm;
      int          n, op, k, j;
      tv[0]  = mk(0, 0, 32'h005, 1, 64'hA55A, 4'h0, 64'h0);
      tv[1]  = mk(1, 0, 32'h005, 1, 64'h0, 4'h0, 64'hA55A);
      tv[2]  = mk(0, 0, 32'h010, 1, 64'h1234, 4'h0, 64'h0);
      tv[3]  = mk(0, 0, 32'h010, 1, 64'hFFFF, 4'h1, 64'h0);
      tv[4]  = mk(1, 0, 32'h010, 1, 64'h0, 4'h0, 64'h12FF);
      tv[5]  = mk(0, 0, 32'h3FF, 3, 64'h3333_2222_1111, 4'h0, 64'h0);
      tv[6]  = mk(1, 0, 32'h3FF, 1, 64'h0, 4'h0, 64'h1111);
      tv[7]  = mk(1, 0, 32'h000, 2, 64'h0, 4'h0, 64'h3333_2222);
      tv[8]  = mk(1, 0, 32'h3FF, 3, 64'h0, 4'h0, 64'h3333_2222_1111);
      tv[9]  = mk(1, 1, 32'h000, 1, 64'h0, 4'h0, 64'h0C81);
      tv[10] = mk(0, 1, 32'h800, 1, 64'h8F17, 4'h0, 64'h0);
      tv[11] = mk(1, 1, 32'h800, 1, 64'h0, 4'h0, 64'h8F17);
      tv[12] = mk(0, 0, 32'h020, 1, 64'hBEEF, 4'h0, 64'h0);
      tv[13] = mk(1, 0, 32'h020, 1, 64'h0, 4'h0, 64'hBEEF);
      repeat (4) @(negedge clk);
      chk("reset_outputs", 32'({dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l}), 32'h005);
      i_rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int v = 0; v < 14; v++) begin
         xfer(tv[v].rd, tv[v].rg, tv[v].a, tv[v].n, tv[v].d, tv[v].hm, 4'h0, 1'b0, 1'b0, got);
         if (tv[v].rd)
            for (int w = 0; w < tv[v].n; w++)
               chk("vec_rd", 32'(got[16*w +: 16]), 32'(tv[v].e[16*w +: 16]));
      end
      xfer(0, 0, 32'h020, 1, 64'hDEAD, 4'h0, 4'h0, 1'b1, 1'b0, got);
      xfer(1, 0, 32'h020, 1, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, got);
      chk("abort_wr_keep", 32'(got[15:0]), 32'hBEEF);
      xfer(1, 0, 32'h005, 2, 64'h0, 4'h0, 4'h0, 1'b1, 1'b0, got);
      xfer(1, 0, 32'h005, 1, 64'h0, 4'h0, 4'h0, 1'b0, 1'b1, got);
      chk("after_rd_abort_stall", 32'(got[15:0]), 32'hA55A);
      @(negedge clk);
      i_rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_outputs", 32'({dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l}), 32'h005);
      i_rst = 1'b0;
      xfer(1, 1, 32'h800, 1, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, got);
      chk("cr0_after_rst", 32'(got[15:0]), 32'h8F1F);
      xfer(1, 0, 32'h005, 1, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, got);
      chk("mem_kept_rst", 32'(got[15:0]), 32'hA55A);
      xfer(0, 1, 32'h800, 2, 64'h1111_5A5A, 4'h0, 4'h0, 1'b0, 1'b0, got);
      xfer(1, 1, 32'h800, 1, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, got);
      chk("cr0_first_word", 32'(got[15:0]), 32'h5A5A);
      @(negedge clk);
      dram_rst_l = 1'b0;
      repeat (2) @(negedge clk);
      dram_rst_l = 1'b1;
      xfer(1, 1, 32'h800, 1, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, got);
      chk("cr0_after_dram_rst", 32'(got[15:0]), 32'h8F1F);
      cr0m = 16'h8F1F;
      repeat (45) begin
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            a = 32'($urandom_range(0, 1023));
            n = $urandom_range(1, 4);
            wd = {$urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
               hm[i] = ($urandom_range(0, 3) == 0);
               lm[i] = ($urandom_range(0, 3) == 0);
            end
            xfer(0, 0, a, n, wd, hm, lm, 1'b0, ($urandom_range(0, 7) == 0), got);
            for (int i = 0; i < n; i++) begin
               j = (int'(a) + i) % 1024;
               if (!hm[i]) begin mm[j][15:8] = wd[16*i+8 +: 8]; kh[j] = 1'b1; end
               if (!lm[i]) begin mm[j][7:0] = wd[16*i +: 8]; kl[j] = 1'b1; end
            end
            qa.push_back(int'(a));
            qn.push_back(n);
         end else if (op <= 6 && qa.size() > 0) begin
            k = $urandom_range(0, qa.size() - 1);
            xfer(1, 0, 32'(qa[k]), qn[k], 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, got);
            for (int i = 0; i < qn[k]; i++) begin
               j = (qa[k] + i) % 1024;
               km = {{8{kh[j]}}, {8{kl[j]}}};
               chk("rnd_mem", 32'(got[16*i +: 16] & km), 32'(mm[j] & km));
            end
         end else if (op == 7) begin
            wd = {32'h0, $urandom};
            xfer(0, 1, 32'h800, $urandom_range(1, 2), wd, 4'h0, 4'h0, 1'b0, 1'b0, got);
            cr0m = wd[15:0];
         end else if (op >= 8) begin
            k = $urandom_range(0, 2);
            a = (k == 0) ? 32'h0 : (k == 1) ? 32'h800 : 32'h1;
            xfer(1, 1, a, 1, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, got);
            chk("rnd_reg", 32'(got[15:0]), 32'((a == 32'h0) ? 16'h0C81 : cr0m));
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
